// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
//   Shared definitions for the 1x3 router packet-flow controller.
//   - NUM_PORTS / ST_W   : output FIFO count and state register width
//   - router_state_e     : binary-encoded controller states
//   - ADDR_INVALID       : header address that selects no FIFO
//   - sel_port()         : picks one per-FIFO flag by header address;
//                          an invalid address returns 0
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ST_W      = 3;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [ST_W-1:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

    // An explicit case is used rather than flags[addr] because address 2'b11
    // lies outside the 3-bit flag vector.
    function automatic logic sel_port(input logic [NUM_PORTS-1:0] flags,
                                      input logic [1:0]           addr);
        logic bit_sel;
        bit_sel = 1'b0;
        case (addr)
            2'd0:    bit_sel = flags[0];
            2'd1:    bit_sel = flags[1];
            2'd2:    bit_sel = flags[2];
            default: bit_sel = 1'b0;
        endcase
        return bit_sel;
    endfunction

endpackage

// File: rtl/router_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// router_fsm_ctrl
//   Packet-flow controller for the 1x3 router. It sequences header decode,
//   payload load, the FIFO-full stall and the parity check, and drives the
//   register stage strobes.
//
//   Ports
//     clk, reset                  rising-edge clock, async active-high reset
//     pkt_valid                   source packet-valid strobe
//     data_in[1:0]                header address bits of the source byte
//     fifo_full                   full flag of the currently selected FIFO
//     fifo_empty_0..2             empty flags of the three FIFOs
//     soft_reset_0..2             timeout soft resets of the three FIFOs
//     parity_done, low_pkt_valid  status returned by the register stage
//     write_enb_reg               write enable toward the selected FIFO
//     detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
//                                 phase strobes (Moore, decoded from state)
//     busy                        back-pressure to the source
//
//   state              | meaning
//   -------------------+----------------------------------------------------
//   DECODE_ADDRESS     | idle; waiting for a valid header (reset state)
//   LOAD_FIRST_DATA    | header byte written to the selected FIFO
//   LOAD_DATA          | payload bytes streaming into the FIFO
//   LOAD_PARITY        | parity byte written after pkt_valid fell
//   FIFO_FULL_STATE    | stalled; selected FIFO is full
//   LOAD_AFTER_FULL    | FIFO drained; write the byte held during the stall
//   WAIT_TILL_EMPTY    | header accepted, but target FIFO still holds data
//   CHECK_PARITY_ERROR | clear the internal parity of the register stage
// -----------------------------------------------------------------------------
module router_fsm_ctrl
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       write_enb_reg,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy
);

    router_state_e          state_q;
    router_state_e          state_d;
    logic [1:0]             addr_q;
    logic [NUM_PORTS-1:0]   fifo_empty_vec;
    logic [NUM_PORTS-1:0]   soft_reset_vec;
    logic                   hdr_valid;
    logic                   hdr_empty;
    logic                   addr_empty;
    logic                   addr_soft_reset;

    assign fifo_empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_reset_vec = {soft_reset_2, soft_reset_1, soft_reset_0};

    // Header decode looks at data_in directly; later states use the latched
    // address so the source byte can move on to payload.
    assign hdr_valid       = pkt_valid && (data_in != ADDR_INVALID);
    assign hdr_empty       = sel_port(fifo_empty_vec, data_in);
    assign addr_empty      = sel_port(fifo_empty_vec, addr_q);
    assign addr_soft_reset = sel_port(soft_reset_vec, addr_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= 2'b00;
        end else if (state_q == DECODE_ADDRESS && pkt_valid) begin
            addr_q <= data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        // A soft reset from the selected FIFO abandons the packet from any
        // active state; it outranks every normal transition.
        if (state_q != DECODE_ADDRESS && addr_soft_reset) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (hdr_valid) begin
                        state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (addr_empty) begin
                        state_d = LOAD_FIRST_DATA;
                    end
                end
                LOAD_FIRST_DATA: begin
                    state_d = LOAD_DATA;
                end
                LOAD_DATA: begin
                    // Full wins over a simultaneous pkt_valid fall; the
                    // register stage flags that case via low_pkt_valid.
                    if (fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        state_d = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        state_d = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                LOAD_PARITY: begin
                    state_d = CHECK_PARITY_ERROR;
                end
                CHECK_PARITY_ERROR: begin
                    state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: begin
                    state_d = DECODE_ADDRESS;
                end
            endcase
        end
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b1;
        case (state_q)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            LOAD_FIRST_DATA: begin
                lfd_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_router_fsm_ctrl
//   Directed bench for router_fsm_ctrl. Outputs are packed as
//   {write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state,
//    rst_int_reg, busy} and compared against hand-written per-state vectors.
// -----------------------------------------------------------------------------
module tb_router_fsm_ctrl;

    localparam logic [7:0] EXP_DEC  = 8'b0100_0000;
    localparam logic [7:0] EXP_LFD  = 8'b1010_0001;
    localparam logic [7:0] EXP_LD   = 8'b1001_0000;
    localparam logic [7:0] EXP_LP   = 8'b1000_0001;
    localparam logic [7:0] EXP_FULL = 8'b0000_0101;
    localparam logic [7:0] EXP_LAF  = 8'b1000_1001;
    localparam logic [7:0] EXP_WAIT = 8'b0000_0001;
    localparam logic [7:0] EXP_CHK  = 8'b0000_0011;

    logic       clk;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       write_enb_reg, detect_add, lfd_state, ld_state;
    logic       laf_state, full_state, rst_int_reg, busy;

    int n_checks = 0;
    int n_fails  = 0;

    router_fsm_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .write_enb_reg (write_enb_reg),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {write_enb_reg, detect_add, lfd_state, ld_state,
                laf_state, full_state, rst_int_reg, busy};
    endfunction

    task automatic check_val(input string tag, input logic [7:0] got,
                             input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_check(input string tag, input logic [7:0] exp);
        tick();
        check_val(tag, outs(), exp);
    endtask

    task automatic enter_ld(input logic [1:0] addr);
        pkt_valid    = 1'b1;
        data_in      = addr;
        fifo_empty_0 = 1'b1;
        fifo_empty_1 = 1'b1;
        fifo_empty_2 = 1'b1;
        step_check("enter_lfd", EXP_LFD);
        step_check("enter_ld", EXP_LD);
    endtask

    initial begin
        reset         = 1'b1;
        pkt_valid     = 1'b0;
        data_in       = 2'b00;
        fifo_full     = 1'b0;
        fifo_empty_0  = 1'b1;
        fifo_empty_1  = 1'b1;
        fifo_empty_2  = 1'b1;
        soft_reset_0  = 1'b0;
        soft_reset_1  = 1'b0;
        soft_reset_2  = 1'b0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;

        tick();
        check_val("reset_state", outs(), EXP_DEC);
        reset = 1'b0;
        step_check("idle", EXP_DEC);

        // Full packet to FIFO 1: LFD, 10 x LOAD_DATA, parity, check, decode.
        pkt_valid = 1'b1;
        data_in   = 2'd1;
        step_check("pkt1_lfd", EXP_LFD);
        step_check("pkt1_ld0", EXP_LD);
        for (int i = 1; i < 10; i++) step_check("pkt1_ld", EXP_LD);
        pkt_valid = 1'b0;
        step_check("pkt1_lp", EXP_LP);
        step_check("pkt1_chk", EXP_CHK);
        step_check("pkt1_dec", EXP_DEC);

        // FIFO 2 busy for 4 cycles: WAIT_TILL_EMPTY, then LFD.
        pkt_valid    = 1'b1;
        data_in      = 2'd2;
        fifo_empty_2 = 1'b0;
        step_check("wait0", EXP_WAIT);
        data_in = 2'd1;  // header moves on; latched address must be used
        for (int i = 1; i < 4; i++) step_check("wait", EXP_WAIT);
        fifo_empty_2 = 1'b1;
        step_check("wait_lfd", EXP_LFD);
        step_check("wait_ld", EXP_LD);

        // Full for 3 cycles while pkt_valid falls; low_pkt_valid resolves it.
        fifo_full = 1'b1;
        pkt_valid = 1'b0;
        step_check("full0", EXP_FULL);
        step_check("full1", EXP_FULL);
        step_check("full2", EXP_FULL);
        fifo_full     = 1'b0;
        low_pkt_valid = 1'b1;
        step_check("laf", EXP_LAF);
        step_check("laf_lp", EXP_LP);
        low_pkt_valid = 1'b0;
        step_check("laf_chk", EXP_CHK);
        step_check("laf_dec", EXP_DEC);

        // Soft reset: only the selected FIFO's soft reset aborts.
        enter_ld(2'd1);
        pkt_valid = 1'b1;
        fifo_full = 1'b1;
        step_check("sr_full", EXP_FULL);
        soft_reset_0 = 1'b1;
        step_check("sr0_ignored", EXP_FULL);
        soft_reset_0 = 1'b0;
        soft_reset_1 = 1'b1;
        step_check("sr1_abort", EXP_DEC);
        soft_reset_1 = 1'b0;
        fifo_full    = 1'b0;
        pkt_valid    = 1'b0;
        step_check("sr_idle", EXP_DEC);

        // Invalid header address 3 is dropped.
        pkt_valid = 1'b1;
        data_in   = 2'b11;
        for (int i = 0; i < 3; i++) step_check("bad_addr", EXP_DEC);
        pkt_valid = 1'b0;

        // LAF back to LOAD_DATA, then LAF with parity_done to DECODE.
        enter_ld(2'd0);
        fifo_full = 1'b1;
        step_check("laf2_full", EXP_FULL);
        fifo_full = 1'b0;
        step_check("laf2_laf", EXP_LAF);
        step_check("laf2_ld", EXP_LD);
        fifo_full = 1'b1;
        step_check("laf3_full", EXP_FULL);
        fifo_full   = 1'b0;
        parity_done = 1'b1;
        step_check("laf3_laf", EXP_LAF);
        step_check("laf3_dec", EXP_DEC);
        parity_done = 1'b0;
        pkt_valid   = 1'b0;

        // CHECK_PARITY_ERROR with FIFO full returns to the stall state.
        enter_ld(2'd2);
        pkt_valid = 1'b0;
        step_check("cpf_lp", EXP_LP);
        fifo_full = 1'b1;
        step_check("cpf_chk", EXP_CHK);
        step_check("cpf_full", EXP_FULL);
        fifo_full = 1'b0;
        step_check("cpf_laf", EXP_LAF);
        parity_done = 1'b1;
        step_check("cpf_dec", EXP_DEC);
        parity_done = 1'b0;

        // Reset mid-LOAD_DATA aborts at once and holds DECODE.
        enter_ld(2'd1);
        reset = 1'b1;
        #1;
        check_val("rst_async", outs(), EXP_DEC);
        step_check("rst_next", EXP_DEC);
        reset     = 1'b0;
        pkt_valid = 1'b0;
        step_check("rst_idle", EXP_DEC);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
